// File: rtl/shift_register_univ.sv
// Universal shift register: hold, shift-left, shift-right and parallel load, with a saturating fill counter.
// Defining SHIFT_REGISTER_UNIV_ROTATE_EN makes ROT=1 during a shift rotate the register instead of taking SER_IN.
module shift_register_univ #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           EN,
  input  logic [1:0]                     MODE,
  input  logic                           SER_IN,
  input  logic                           ROT,
  input  logic [WIDTH-1:0]               DATA_IN,
  output logic [WIDTH-1:0]               DATA_OUT,
  output logic                           Q_N,
  output logic                           SER_OUT_L,
  output logic                           SER_OUT_R,
  output logic                           ACTIVE,
  output logic [$clog2(WIDTH+1)-1:0]     COUNT,
  output logic                           FULL,
  output logic                           DONE
);

  localparam int             CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  COUNT_MAX = CW'(WIDTH);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHL   = 2'b01;
  localparam logic [1:0] MODE_SHR   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] data_reg, data_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             done_reg, done_next;

  logic             rot_active;
  logic             sin_left, sin_right;
  logic [WIDTH-1:0] shl_val, shr_val;
  logic             shifting;

`ifdef SHIFT_REGISTER_UNIV_ROTATE_EN
  assign rot_active = ROT;
`else
  logic unused_rot;
  assign unused_rot = ROT;
  assign rot_active = 1'b0;
`endif

  // On rotate the bit leaving the register re-enters at the other end.
  assign sin_left  = rot_active ? data_reg[WIDTH-1] : SER_IN;
  assign sin_right = rot_active ? data_reg[0]       : SER_IN;

  assign shl_val[0]       = sin_left;
  assign shr_val[WIDTH-1] = sin_right;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign shl_val[gi]   = data_reg[gi-1];
      assign shr_val[gi-1] = data_reg[gi];
    end
  endgenerate

  always_comb begin
    data_next  = data_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    shifting   = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_SHL: begin
          data_next = shl_val;
          shifting  = 1'b1;
        end
        MODE_SHR: begin
          data_next = shr_val;
          shifting  = 1'b1;
        end
        MODE_LOAD: begin
          data_next  = DATA_IN;
          count_next = '0;
        end
        default: ;
      endcase
    end
    // DONE marks only the WIDTH-1 -> WIDTH transition, so saturation cannot re-fire it.
    if (shifting && (count_reg < COUNT_MAX)) begin
      count_next = count_reg + CW'(1);
      done_next  = (count_reg == COUNT_MAX - CW'(1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_reg  <= INIT;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      data_reg  <= data_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  assign DATA_OUT  = data_reg;
  assign Q_N       = ~data_reg[WIDTH-1];
  assign SER_OUT_L = data_reg[WIDTH-1];
  assign SER_OUT_R = data_reg[0];
  assign ACTIVE    = !RESET && EN && (MODE != MODE_HOLD);
  assign COUNT     = count_reg;
  assign FULL      = (count_reg == COUNT_MAX);
  assign DONE      = done_reg;

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8, INIT=0) using an expectation queue.
module tb_shift_register_univ;

  logic       CLK;
  logic       RESET;
  logic       EN;
  logic [1:0] MODE;
  logic       SER_IN;
  logic       ROT;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       Q_N;
  logic       SER_OUT_L;
  logic       SER_OUT_R;
  logic       ACTIVE;
  logic [3:0] COUNT;
  logic       FULL;
  logic       DONE;

  shift_register_univ #(.WIDTH(8), .INIT(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .SER_IN(SER_IN), .ROT(ROT),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .Q_N(Q_N), .SER_OUT_L(SER_OUT_L),
    .SER_OUT_R(SER_OUT_R), .ACTIVE(ACTIVE), .COUNT(COUNT), .FULL(FULL), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   done_seen;

  task automatic sb_push(input string tag, input int value);
    exp_t e;
    e.tag   = tag;
    e.value = 16'(value);
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %h, nothing queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) n_pass++;
      else begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", e.tag, obs, e.value);
        $error("check %s mismatch", e.tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    $display("cycle rst=%0b en=%0b mode=%0d sin=%0b -> data_out=%h count=%0d full=%0b done=%0b",
             RESET, EN, MODE, SER_IN, DATA_OUT, COUNT, FULL, DONE);
  endtask

  task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                       input logic sin, input logic [7:0] din);
    RESET   = rst;
    EN      = en;
    MODE    = mode;
    SER_IN  = sin;
    DATA_IN = din;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pattern;
    logic [7:0] exp_data;
    ROT = 1'b0;

    // Reset with load requested: reset must win
    drive(1'b1, 1'b1, 2'b11, 1'b0, 8'hFF);
    sb_push("active_in_reset", 0);
    chk(16'(ACTIVE));
    tick();
    tick();
    sb_push("rst_data", 8'h00); sb_push("rst_qn", 1); sb_push("rst_count", 0);
    sb_push("rst_full", 0);     sb_push("rst_done", 0); sb_push("rst_active", 0);
    sb_push("rst_serl", 0);     sb_push("rst_serr", 0);
    chk(16'(DATA_OUT)); chk(16'(Q_N)); chk(16'(COUNT));
    chk(16'(FULL)); chk(16'(DONE)); chk(16'(ACTIVE));
    chk(16'(SER_OUT_L)); chk(16'(SER_OUT_R));

    // Parallel load then hold
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'hA5);
    sb_push("load_active", 1);
    chk(16'(ACTIVE));
    tick();
    sb_push("load_data", 8'hA5); sb_push("load_qn", 0); sb_push("load_count", 0);
    chk(16'(DATA_OUT)); chk(16'(Q_N)); chk(16'(COUNT));
    drive(1'b0, 1'b1, 2'b00, 1'b1, 8'h00);
    sb_push("hold_active", 0);
    chk(16'(ACTIVE));
    for (int i = 0; i < 3; i++) begin
      tick();
      sb_push("hold_data", 8'hA5); sb_push("hold_count", 0); sb_push("hold_done", 0);
      chk(16'(DATA_OUT)); chk(16'(COUNT)); chk(16'(DONE));
    end

    // Disabled shift request: nothing changes
    drive(1'b0, 1'b0, 2'b01, 1'b1, 8'h00);
    sb_push("dis_active", 0);
    chk(16'(ACTIVE));
    for (int i = 0; i < 2; i++) begin
      tick();
      sb_push("dis_data", 8'hA5); sb_push("dis_count", 0);
      chk(16'(DATA_OUT)); chk(16'(COUNT));
    end

    // Framed shift-left of 1,0,1,1,0,0,1,0 from 0x00
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h00);
    tick();
    sb_push("frame_load", 8'h00);
    chk(16'(DATA_OUT));
    pattern  = 8'b1011_0010;
    exp_data = 8'h00;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 2'b01, pattern[7-i], 8'h00);
      exp_data = {exp_data[6:0], pattern[7-i]};
      tick();
      sb_push("shl_data", exp_data); sb_push("shl_count", i + 1);
      sb_push("shl_full", (i == 7) ? 1 : 0); sb_push("shl_done", (i == 7) ? 1 : 0);
      chk(16'(DATA_OUT)); chk(16'(COUNT)); chk(16'(FULL)); chk(16'(DONE));
    end
    sb_push("frame_word", 8'hB2);
    chk(16'(DATA_OUT));

    // Ninth shift: count saturates, no second DONE
    drive(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
    tick();
    sb_push("sat_data", 8'h65); sb_push("sat_count", 8);
    sb_push("sat_full", 1);     sb_push("sat_done", 0);
    chk(16'(DATA_OUT)); chk(16'(COUNT)); chk(16'(FULL)); chk(16'(DONE));

    // Shift-right from 0x81
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h81);
    tick();
    sb_push("reload_count", 0); sb_push("reload_full", 0);
    chk(16'(COUNT)); chk(16'(FULL));
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8'h00);
    sb_push("shr_serr_pre", 1); sb_push("shr_serl_pre", 1);
    chk(16'(SER_OUT_R)); chk(16'(SER_OUT_L));
    tick();
    sb_push("shr_data", 8'h40); sb_push("shr_count", 1);
    chk(16'(DATA_OUT)); chk(16'(COUNT));

    // Rotate-left request from 0x81
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h81);
    tick();
    ROT = 1'b1;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    tick();
`ifdef SHIFT_REGISTER_UNIV_ROTATE_EN
    sb_push("rot_data", 8'h03);
`else
    sb_push("rot_data", 8'h02);
`endif
    sb_push("rot_count", 1);
    chk(16'(DATA_OUT)); chk(16'(COUNT));
    ROT = 1'b0;

    // Load on the seventh-shift boundary wins over the frame
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
      tick();
    end
    sb_push("pre_load_data", 8'h7F); sb_push("pre_load_count", 7);
    chk(16'(DATA_OUT)); chk(16'(COUNT));
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h3C);
    tick();
    sb_push("lw_data", 8'h3C); sb_push("lw_count", 0); sb_push("lw_done", 0);
    chk(16'(DATA_OUT)); chk(16'(COUNT)); chk(16'(DONE));

    // Reset mid-frame after 7 shifts
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
      tick();
      if (DONE !== 1'b0) done_seen++;
    end
    drive(1'b1, 1'b1, 2'b01, 1'b1, 8'h00);
    sb_push("mid_rst_active", 0);
    chk(16'(ACTIVE));
    tick();
    if (DONE !== 1'b0) done_seen++;
    sb_push("mid_rst_data", 8'h00); sb_push("mid_rst_count", 0); sb_push("mid_rst_done", 0);
    chk(16'(DATA_OUT)); chk(16'(COUNT)); chk(16'(DONE));
    drive(1'b0, 1'b1, 2'b00, 1'b0, 8'h00);
    tick();
    if (DONE !== 1'b0) done_seen++;
    sb_push("mid_rst_no_done", 0);
    chk(16'(done_seen));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal shift register for the datapath serialisers, and the next generation of the 4-bit serial-load shift register. It generalises width and reset value and adds hold, shift-left, shift-right and parallel-load modes. A saturating fill counter with FULL/DONE flags frames serial words. An optional rotate feature is selected at compile time. It sits between the serial pin interfaces and the parallel datapath registers.

## Interface
Parameters:
- WIDTH, 8: register width in bits; legal range WIDTH ≥ 2.
- INIT, all-zero (WIDTH bits): value DATA_OUT takes on reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  operation enable; 0 holds all state.
- MODE  in  2  operation select: 00 hold, 01 shift-left, 10 shift-right, 11 parallel load.
- SER_IN  in  1  serial input bit.
- ROT  in  1  rotate select; only used when the Configuration macro is defined.
- DATA_IN  in  WIDTH  parallel load value.
- DATA_OUT  out  WIDTH  register contents.
- Q_N  out  1  ~DATA_OUT[WIDTH-1] (combinational).
- SER_OUT_L  out  1  DATA_OUT[WIDTH-1].
- SER_OUT_R  out  1  DATA_OUT[0].
- ACTIVE  out  1  combinational; equals !RESET && EN && (MODE != 00).
- COUNT  out  $clog2(WIDTH+1)  number of shifts since the last reset or parallel load; saturates at WIDTH.
- FULL  out  1  COUNT == WIDTH.
- DONE  out  1  registered one-cycle pulse.

## Operation
- Priority order: RESET, then EN=0, then MODE.
- RESET=1: DATA_OUT=INIT, COUNT=0, DONE=0. MODE, EN and data inputs are ignored.
- EN=0: DATA_OUT, COUNT and DONE hold, except that DONE is forced to 0.
- MODE 00 (hold): DATA_OUT and COUNT hold; DONE=0.
- MODE 01 (shift-left): DATA_OUT ← {DATA_OUT[WIDTH-2:0], sin}.
- MODE 10 (shift-right): DATA_OUT ← {sin, DATA_OUT[WIDTH-1:1]}.
- For both shift modes, sin is SER_IN, or the bit shifted out when rotate is active (see Configuration).
- Each shift increments COUNT if COUNT < WIDTH. At COUNT == WIDTH, COUNT holds (saturates).
- MODE 11 (parallel load): DATA_OUT ← DATA_IN, COUNT ← 0, DONE ← 0.
- DONE is set to 1 on exactly the edge where COUNT goes from WIDTH-1 to WIDTH. It is 0 on every other edge.
- DONE never re-pulses while COUNT is saturated. A parallel load or reset is required to re-arm it.
- Q_N, SER_OUT_L, SER_OUT_R, FULL and ACTIVE are pure functions of the current state and inputs.

## Timing
- Shift and load latency is 1 cycle: the new DATA_OUT is visible after the rising edge on which the command was sampled.
- DONE and FULL both rise after the edge of the WIDTH-th shift.
- DONE falls after the next edge; FULL stays high until a load or reset.
- Reset values of the outputs:
  - DATA_OUT = INIT; Q_N = ~INIT[WIDTH-1]; SER_OUT_L = INIT[WIDTH-1]; SER_OUT_R = INIT[0].
  - COUNT = 0, FULL = 0, DONE = 0.
  - ACTIVE = 0 while RESET is high.
- Reset asserted mid-frame takes effect on the next edge. No DONE is produced even if that edge would have completed the frame.
- A load in the same cycle that COUNT = WIDTH-1 wins: COUNT becomes 0 and no DONE is produced.

## Configuration
- SHIFT_REGISTER_UNIV_ROTATE_EN defined:
  - ROT=1 during a shift selects rotate; sin = DATA_OUT[WIDTH-1] for shift-left and DATA_OUT[0] for shift-right.
  - COUNT and DONE behave exactly as for a normal shift.
- Macro undefined:
  - ROT is ignored (port retained for interface stability).
  - sin is always SER_IN.

## Test plan
All scenarios use WIDTH=8 and INIT=0x00.
- Reset: RESET=1 for 2 cycles with EN=1, MODE=11, DATA_IN=0xFF -> DATA_OUT=0x00, Q_N=1, COUNT=0, FULL=0, DONE=0, ACTIVE=0.
- Load/hold: MODE=11 with DATA_IN=0xA5, then MODE=00 for 3 cycles -> DATA_OUT=0xA5 throughout, Q_N=0, COUNT=0. Then EN=0 with MODE=01 for 2 cycles -> no change.
- Framed shift-left:
  - Stimulus: from 0x00, 8 shift-left cycles with SER_IN=1,0,1,1,0,0,1,0.
  - Response: DATA_OUT=0xB2, COUNT=8, FULL=1, DONE high for exactly 1 cycle.
  - A 9th shift with SER_IN=1 gives DATA_OUT=0x65, COUNT=8, no DONE.
- Shift-right: load 0x81, shift-right with SER_IN=0 -> SER_OUT_R=1 before the edge, then DATA_OUT=0x40, COUNT=1.
- Rotate:
  - Load 0x81, then shift-left with ROT=1, SER_IN=0.
  - With SHIFT_REGISTER_UNIV_ROTATE_EN: DATA_OUT=0x03.
  - Without the macro: DATA_OUT=0x02.
- Reset mid-frame: after 7 shifts, assert RESET with EN=1, MODE=01 -> next cycle DATA_OUT=0x00, COUNT=0, and DONE never pulses.
